// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// single-port memory and decodes the instruction register into ALU and strobe controls.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        mem_ready_i,
  input  logic        br_eq_i,
  input  logic        br_lt_i,
  input  logic        br_ltu_i,
  output logic [3:0]  alu_op_o,
  output logic        op_a_sel_o,
  output logic        op_b_sel_o,
  output logic        ir_we_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_addr_sel_o,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_sel_o,
  output logic        retire_o,
  output logic        halt_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                         OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_OR = 4'd8, OP_AND = 4'd9, OP_LUI = 4'd10;

  // The PC register lives in the datapath; only its alignment is checked here.
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("RESET_PC must be word aligned");
  end

  state_t state, state_next;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  logic is_r, is_i, is_lui, is_auipc, is_jal, is_jalr, is_br, is_load, is_store, is_fence;
  logic is_ecall, is_ebreak, legal, br_taken;
  logic [3:0] arith_op;

  assign is_r      = opcode == 7'b0110011;
  assign is_i      = opcode == 7'b0010011;
  assign is_lui    = opcode == 7'b0110111;
  assign is_auipc  = opcode == 7'b0010111;
  assign is_jal    = opcode == 7'b1101111;
  assign is_jalr   = opcode == 7'b1100111;
  assign is_br     = opcode == 7'b1100011;
  assign is_load   = opcode == 7'b0000011;
  assign is_store  = opcode == 7'b0100011;
  assign is_fence  = opcode == 7'b0001111;
  assign is_ecall  = instr_i == 32'h0000_0073;
  assign is_ebreak = instr_i == 32'h0010_0073;

  always_comb begin
    logic r_f7_ok, i_f7_ok, br_f3_ok;
    r_f7_ok  = (funct7 == 7'h00) ||
               (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
    i_f7_ok  = (funct3 == 3'b001) ? (funct7 == 7'h00) :
               (funct3 == 3'b101) ? (funct7 == 7'h00 || funct7 == 7'h20) : 1'b1;
    br_f3_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
    legal = ((is_r && r_f7_ok) || (is_i && i_f7_ok) || (is_br && br_f3_ok) ||
             is_lui || is_auipc || is_jal || is_jalr || is_load || is_store || is_fence)
            && !is_ecall && !is_ebreak;
  end

  // SUB only exists on R-type; funct7[5] selects SRA for both R-type and shift-immediate.
  always_comb begin
    arith_op = OP_ADD;
    case (funct3)
      3'b000:  arith_op = (is_r && funct7[5]) ? OP_SUB : OP_ADD;
      3'b001:  arith_op = OP_SLL;
      3'b010:  arith_op = OP_SLT;
      3'b011:  arith_op = OP_SLTU;
      3'b100:  arith_op = OP_XOR;
      3'b101:  arith_op = funct7[5] ? OP_SRA : OP_SRL;
      3'b110:  arith_op = OP_OR;
      default: arith_op = OP_AND;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = br_eq_i;
      3'b001:  br_taken = !br_eq_i;
      3'b100:  br_taken = br_lt_i;
      3'b101:  br_taken = !br_lt_i;
      3'b110:  br_taken = br_ltu_i;
      3'b111:  br_taken = !br_ltu_i;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_RST;
    else       state <= state_next;
  end

  assign state_o = state;

  always_comb begin
    state_next     = state;
    alu_op_o       = OP_ADD;
    op_a_sel_o     = 1'b0;
    op_b_sel_o     = 1'b0;
    ir_we_o        = 1'b0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    rf_we_o        = 1'b0;
    wb_sel_o       = 2'd0;
    pc_we_o        = 1'b0;
    pc_sel_o       = 2'd0;
    retire_o       = 1'b0;
    halt_o         = 1'b0;
    case (state)
      S_RST: state_next = S_FETCH;
      S_FETCH: begin
        mem_req_o = 1'b1;
        ir_we_o   = mem_ready_i;
        if (mem_ready_i) state_next = S_DECODE;
      end
      S_DECODE: state_next = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        state_next = (is_load || is_store) ? S_MEM : S_WB;
        if (is_r || is_i) begin
          alu_op_o   = arith_op;
          op_b_sel_o = is_i;
        end else if (is_lui) begin
          alu_op_o   = OP_LUI;
          op_b_sel_o = 1'b1;
        end else if (is_auipc || is_jal || is_br) begin
          op_a_sel_o = 1'b1;
          op_b_sel_o = 1'b1;
        end else if (is_jalr || is_load || is_store) begin
          op_b_sel_o = 1'b1;
        end
      end
      S_MEM: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        mem_we_o       = is_store;
        if (mem_ready_i) state_next = S_WB;
      end
      S_WB: begin
        state_next = S_FETCH;
        pc_we_o    = 1'b1;
        retire_o   = 1'b1;
        rf_we_o    = is_r || is_i || is_lui || is_auipc || is_load || is_jal || is_jalr;
        if (is_load)               wb_sel_o = 2'd1;
        else if (is_jal || is_jalr) wb_sel_o = 2'd2;
        if (is_jal)                 pc_sel_o = 2'd1;
        else if (is_jalr)           pc_sel_o = 2'd2;
        else if (is_br && br_taken) pc_sel_o = 2'd1;
      end
      S_TRAP: halt_o = 1'b1;
      default: state_next = S_RST;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction cycle-by-cycle checks plus a scoreboard
// of expected write-back controls and retire latency.
module tb_multicycle_ctrl;

  localparam logic [2:0] ST_RST = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3,
                         ST_MEM = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd6;
  localparam int W = 13;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        mem_ready = 1'b0;
  logic        br_eq = 1'b0, br_lt = 1'b0, br_ltu = 1'b0;
  logic [3:0]  alu_op;
  logic        op_a_sel, op_b_sel, ir_we, mem_req, mem_we, mem_addr_sel, rf_we;
  logic [1:0]  wb_sel, pc_sel;
  logic        pc_we, retire, halt;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];

  multicycle_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .mem_ready_i(mem_ready),
    .br_eq_i(br_eq), .br_lt_i(br_lt), .br_ltu_i(br_ltu),
    .alu_op_o(alu_op), .op_a_sel_o(op_a_sel), .op_b_sel_o(op_b_sel), .ir_we_o(ir_we),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_sel_o(mem_addr_sel),
    .rf_we_o(rf_we), .wb_sel_o(wb_sel), .pc_we_o(pc_we), .pc_sel_o(pc_sel),
    .retire_o(retire), .halt_o(halt), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] out_vec();
    return {alu_op, op_a_sel, op_b_sel, ir_we, mem_req, mem_we, mem_addr_sel, rf_we,
            wb_sel, pc_we, pc_sel, retire, halt};
  endfunction

  function automatic logic [6:0] strobes();
    return {ir_we, mem_req, mem_we, rf_we, pc_we, retire, halt};
  endfunction

  // Leaves the DUT in RST with reset released; the next cycle is FETCH.
  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("rst_state", state, ST_RST);
    check("rst_outs", out_vec(), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic eq, input logic lt,
                           input logic ltu, input int fw, input int mw,
                           input logic [3:0] alu, input logic a, input logic b,
                           input logic mem, input logic st, input logic rf,
                           input logic [1:0] wb, input logic [1:0] pc);
    int lat, cyc;
    logic [2:0] es;
    logic [W-1:0] e;
    bit done;
    lat = 4 + fw + (mem ? 1 + mw : 0);
    instr = ins;
    br_eq = eq; br_lt = lt; br_ltu = ltu;
    exp_q.push_back({rf, wb, pc, 8'(lat)});
    cyc = 0;
    done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc <= fw + 1)                 es = ST_FETCH;
      else if (cyc == fw + 2)            es = ST_DECODE;
      else if (cyc == fw + 3)            es = ST_EXEC;
      else if (mem && cyc <= fw + 4 + mw) es = ST_MEM;
      else                               es = ST_WB;
      if (es == ST_FETCH)    mem_ready = (cyc == fw + 1);
      else if (es == ST_MEM) mem_ready = (cyc == fw + 4 + mw);
      else                   mem_ready = 1'($urandom_range(0, 1));
      #1;
      check("state", state, es);
      case (es)
        ST_FETCH:  check("fetch", {mem_req, mem_addr_sel, mem_we, ir_we},
                         {1'b1, 1'b0, 1'b0, mem_ready});
        ST_DECODE: check("decode", strobes(), 0);
        ST_EXEC:   check("exec", {alu_op, op_a_sel, op_b_sel, mem_req, rf_we, pc_we},
                         {alu, a, b, 3'b000});
        ST_MEM:    check("mem", {mem_req, mem_addr_sel, mem_we, ir_we, pc_we},
                         {1'b1, 1'b1, st, 2'b00});
        default: ;
      endcase
      if (retire) begin
        done = 1;
        if (exp_q.size() == 0) check("sb_empty", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wb_rf_wb_pc_lat", {rf_we, wb_sel, pc_sel, 8'(cyc)}, e);
          check("wb_pc_we", {pc_we, mem_req, halt}, 3'b100);
        end
      end
    end
    if (!done) check("retire_timeout", cyc, lat);
    mem_ready = 1'b0;
  endtask

  task automatic run_trap(input logic [31:0] ins);
    instr = ins;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      mem_ready = (c == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (c == 1)      check("trap_fetch", state, ST_FETCH);
      else if (c == 2) check("trap_decode", state, ST_DECODE);
      else check("trap_hold", {state, strobes()}, {ST_TRAP, 7'b0000001});
    end
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", $time, 200000);
    $fatal(1, "bench timed out");
  end

  initial begin
    do_reset();
    //        instr         eq lt ltu fw mw alu  a  b  mem st rf wb pc
    run_instr(32'h002081B3, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1, 2'd0, 2'd0); // add
    run_instr(32'h4020D193, 0, 0, 0, 0, 0, 4'd7, 0, 1, 0, 0, 1, 2'd0, 2'd0); // srai
    run_instr(32'h40208193, 0, 0, 0, 0, 0, 4'd0, 0, 1, 0, 0, 1, 2'd0, 2'd0); // addi f7[5]
    run_instr(32'h0000A183, 0, 0, 0, 0, 3, 4'd0, 0, 1, 1, 0, 1, 2'd1, 2'd0); // lw, 3 waits
    run_instr(32'h00209463, 1, 0, 0, 0, 0, 4'd0, 1, 1, 0, 0, 0, 2'd0, 2'd0); // bne not taken
    run_instr(32'h00209463, 0, 0, 0, 0, 0, 4'd0, 1, 1, 0, 0, 0, 2'd0, 2'd1); // bne taken
    run_instr(32'h000080E7, 0, 0, 0, 0, 0, 4'd0, 0, 1, 0, 0, 1, 2'd2, 2'd2); // jalr
    run_instr(32'h008000EF, 0, 0, 0, 1, 0, 4'd0, 1, 1, 0, 0, 1, 2'd2, 2'd1); // jal
    run_instr(32'h0020A023, 0, 0, 0, 2, 1, 4'd0, 0, 1, 1, 1, 0, 2'd0, 2'd0); // sw
    run_instr(32'h123452B7, 0, 0, 0, 0, 0, 4'd10, 0, 1, 0, 0, 1, 2'd0, 2'd0); // lui
    run_instr(32'h00001297, 0, 0, 0, 0, 0, 4'd0, 1, 1, 0, 0, 1, 2'd0, 2'd0); // auipc
    run_instr(32'h402081B3, 0, 0, 0, 0, 0, 4'd1, 0, 0, 0, 0, 1, 2'd0, 2'd0); // sub
    run_instr(32'h002091B3, 0, 0, 0, 0, 0, 4'd2, 0, 0, 0, 0, 1, 2'd0, 2'd0); // sll
    run_instr(32'h0020A1B3, 0, 0, 0, 0, 0, 4'd3, 0, 0, 0, 0, 1, 2'd0, 2'd0); // slt
    run_instr(32'h0020B1B3, 0, 0, 0, 0, 0, 4'd4, 0, 0, 0, 0, 1, 2'd0, 2'd0); // sltu
    run_instr(32'h0020C1B3, 0, 0, 0, 0, 0, 4'd5, 0, 0, 0, 0, 1, 2'd0, 2'd0); // xor
    run_instr(32'h0020D1B3, 0, 0, 0, 0, 0, 4'd6, 0, 0, 0, 0, 1, 2'd0, 2'd0); // srl
    run_instr(32'h4020D1B3, 0, 0, 0, 0, 0, 4'd7, 0, 0, 0, 0, 1, 2'd0, 2'd0); // sra
    run_instr(32'h0020E1B3, 0, 0, 0, 0, 0, 4'd8, 0, 0, 0, 0, 1, 2'd0, 2'd0); // or
    run_instr(32'h0020F1B3, 0, 0, 0, 0, 0, 4'd9, 0, 0, 0, 0, 1, 2'd0, 2'd0); // and
    run_instr(32'h0050A193, 0, 0, 0, 0, 0, 4'd3, 0, 1, 0, 0, 1, 2'd0, 2'd0); // slti
    run_instr(32'h0000000F, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0); // fence
    run_instr(32'h0020C463, 0, 1, 0, 0, 0, 4'd0, 1, 1, 0, 0, 0, 2'd0, 2'd1); // blt taken
    run_instr(32'h0020F463, 0, 0, 1, 0, 0, 4'd0, 1, 1, 0, 0, 0, 2'd0, 2'd0); // bgeu not taken
    run_instr(32'h00208463, 1, 0, 0, 0, 0, 4'd0, 1, 1, 0, 0, 0, 2'd0, 2'd1); // beq taken
    for (int k = 0; k < 4; k++) begin
      run_instr(32'h0000A183, 0, 0, 0, $urandom_range(0, 2), $urandom_range(0, 3),
                4'd0, 0, 1, 1, 0, 1, 2'd1, 2'd0);
      run_instr(32'h0020A023, 0, 0, 0, $urandom_range(0, 2), $urandom_range(0, 3),
                4'd0, 0, 1, 1, 1, 0, 2'd0, 2'd0);
    end

    run_trap(32'h00000073); // ecall
    run_trap(32'h00100073); // ebreak
    run_trap(32'h022081B3); // R-type bad funct7
    run_trap(32'h40209193); // slli with funct7[5]
    run_trap(32'h0020A463); // branch funct3 010
    run_trap(32'h00000000); // unknown opcode

    // Abort a load while it is waiting in MEM.
    instr = 32'h0000A183;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      mem_ready = (c == 1);
    end
    #1;
    check("abort_pre_mem", {state, mem_req, mem_addr_sel}, {ST_MEM, 2'b11});
    #1 rst = 1'b1;
    #1;
    check("abort_state", state, ST_RST);
    check("abort_outs", out_vec(), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check("abort_hold", {mem_req, pc_we, rf_we, retire}, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    run_instr(32'h002081B3, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1, 2'd0, 2'd0);

    check("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
